// File: rtl/mult_operand_sequencer_pkg.sv
// Shared types and constants for the multiplier operand sequencer.
// The timeout is derived from operand width so a slow multiplier still has headroom.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    function automatic int timeout_cycles(input int n);
        return 4 * n + 8;
    endfunction

endpackage

// File: rtl/mult_operand_sequencer_fifo.sv
// Operand-pair FIFO with a registered occupancy count.
// There is no bypass path: a pair written on an edge is visible at the head only afterwards.
module operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Feeds queued operand pairs to an external multiplier one at a time and
// presents each product on a valid/ready output, flagging a hung multiplier.
module mult_operand_sequencer
    import mult_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_multiplicand,
    input  logic [N-1:0]             in_multiplier,
    output logic                     mul_start,
    output logic [N-1:0]             mul_multiplicand,
    output logic [N-1:0]             mul_multiplier,
    input  logic [2*N:0]             mul_product,
    input  logic                     mul_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N:0]             out_product,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_timeout
);
    localparam int TIMEOUT = timeout_cycles(N);
    localparam int TW      = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   timer;
    logic [2*N-1:0]  head_pair;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_en;
    logic            capture;
    logic            expire;
    logic            can_issue;

    operand_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid),
        .push_data ({in_multiplicand, in_multiplier}),
        .pop       (pop_en),
        .pop_data  (head_pair),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign can_issue = !fifo_empty && (!out_valid || out_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (can_issue) next_state = S_START;
            S_START: next_state = S_WAIT;
            S_WAIT:  if (mul_done || timer == TW'(TIMEOUT - 1)) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mul_start = (state == S_START);
        pop_en    = (state == S_IDLE) && can_issue;
        capture   = (state == S_WAIT) && mul_done;
        expire    = (state == S_WAIT) && !mul_done && (timer == TW'(TIMEOUT - 1));
    end

    // A capture on the same edge as a downstream handshake keeps out_valid set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer            <= '0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            err_timeout      <= 1'b0;
        end else begin
            timer <= (state == S_WAIT && next_state == S_WAIT) ? timer + TW'(1) : '0;
            if (pop_en) begin
                mul_multiplicand <= head_pair[2*N-1:N];
                mul_multiplier   <= head_pair[N-1:0];
            end
            if (capture) begin
                out_valid   <= 1'b1;
                out_product <= mul_product;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (expire) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mult_operand_sequencer.md
MULT_OPERAND_SEQUENCER -- requirements
Module: mult_operand_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: operand width; must match the downstream multiplier.
REQ-002 SHALL have parameter DEPTH, default 4: operand FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream operand-pair handshake.
REQ-006 SHALL have ports in_multiplicand and in_multiplier, both input, N bits: upstream operands.
REQ-007 SHALL have port mul_start, output, 1 bit: start pulse to the multiplier.
REQ-008 SHALL have ports mul_multiplicand and mul_multiplier, both output, N bits: operands to the multiplier.
REQ-009 SHALL have port mul_product, input, 2N+1 bits: multiplier result; valid only while mul_done=1.
REQ-010 SHALL have port mul_done, input, 1 bit: one-cycle completion pulse from the multiplier.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_product (output, 2N+1): downstream result handshake.
REQ-012 SHALL have port fifo_level, output, $clog2(DEPTH)+1 bits: occupied FIFO entries.
REQ-013 SHALL have port err_timeout, output, 1 bit: sticky flag, multiplier failed to complete.

Function
REQ-014 SHALL accept an operand pair into the FIFO on a clock edge where in_valid=1 and in_ready=1.
REQ-015 SHALL drive in_ready = (fifo_level < DEPTH), a function of registered state only; pairs are never dropped when full.
REQ-016 SHALL implement a FIFO with no bypass: a pair written at edge t can be popped no earlier than edge t+1.
REQ-017 SHALL implement FSM states S_IDLE, S_START, S_WAIT.
REQ-018 S_IDLE SHALL pop the FIFO head into the operand registers and go to S_START when the FIFO is non-empty and (out_valid=0 or out_ready=1); otherwise it SHALL remain in S_IDLE.
REQ-019 S_START SHALL assert mul_start=1 for exactly that one cycle, then go to S_WAIT.
REQ-020 S_WAIT SHALL capture mul_product into out_product, set out_valid=1 on the next edge, and return to S_IDLE when mul_done=1.
REQ-021 SHALL hold mul_multiplicand and mul_multiplier stable from S_START until the cycle mul_done is sampled.
REQ-022 SHALL clear out_valid on an edge where out_valid=1 and out_ready=1, unless a new capture occurs on the same edge, in which case the new value SHALL win.
REQ-023 SHALL hold out_product unchanged while out_valid=1 and out_ready=0.
REQ-024 SHALL count cycles in S_WAIT; when the count reaches TIMEOUT = 4N+8 without mul_done, it SHALL set err_timeout, discard the pair, and return to S_IDLE.
REQ-025 SHALL ignore mul_done outside S_WAIT.
REQ-026 SHALL allow a simultaneous push and pop, leaving fifo_level unchanged and wrapping the pointers modulo DEPTH.
REQ-027 SHALL produce minimum latency from FIFO write at edge t as follows: pop at edge t+1; mul_start high during the cycle after edge t+1; out_valid high the cycle after mul_done.

Reset
REQ-028 Reset SHALL force: FSM to S_IDLE, FIFO empty, fifo_level=0, in_ready=1, mul_start=0, mul_multiplicand=0, mul_multiplier=0, out_valid=0, out_product=0, err_timeout=0, timeout counter=0.
REQ-029 Reset mid-operation SHALL abandon the in-flight pair and all FIFO contents without emitting a result.

Structure
REQ-030 Package mult_seq_pkg SHALL hold the FSM state enum and the TIMEOUT computation as a function of N.
REQ-031 The FIFO SHALL be a sub-module named operand_fifo, parameterized by width 2N and DEPTH; the multiplier SHALL remain external.

Verification
REQ-032 With N=4 and a behavioural multiplier model: push (3,5) -> one mul_start pulse, then out_valid=1 with out_product=15.
REQ-033 Push (15,15) then (0,9) with out_ready=1 -> results 225 then 0, in order, with exactly two mul_start pulses.
REQ-034 Hold out_ready=0 and push pairs continuously -> exactly DEPTH+1=5 pairs accepted before in_ready=0; releasing out_ready drains all 5 results in order.
REQ-035 Tie mul_done=0 and push (2,2) -> err_timeout=1 after 24 cycles in S_WAIT, FSM returns to S_IDLE, and no out_valid pulse occurs.
REQ-036 Assert reset during S_WAIT with 3 pairs queued -> all outputs take their reset values, and a subsequent mul_done produces no result.
